riscv_mem_loader: RTL and testbench
===================================

// Module: riscv_mem_loader
// PURPOSE
//  Program loader upstream of the single-SRAM RISC-V harness. Takes a byte
//  stream (debug/UART), assembles LE words, writes them into the shared SRAM
//  through the memory-request mux, and holds the RISC-V core in reset until
//  a load completes. Per load: 4-byte base address, 4-byte word count N,
//  then N 4-byte data words. All multi-byte fields are little-endian.
// PARAMETERS
//  ADDR_MASK  32'h0000_fffc  mask applied to every write address (64KB SRAM, word aligned)
// PORTS
//  clk              in   1   clock
//  clk__enable      in   1   clock enable; all state advances only when high
//  reset            in   1   asynchronous reset, active high
//  load_start       in   1   pulse: begin a new load (honoured in IDLE/DONE only)
//  byte_valid       in   1   stream byte valid
//  byte_data        in   8   stream byte
//  byte_ready       out  1   loader accepts byte this cycle
//  mem_req_valid    out  1   SRAM write request
//  mem_req_address  out  32  write address (already masked)
//  mem_req_data     out  32  write data
//  mem_req_byte_en  out  4   always 4'hf when mem_req_valid
//  mem_req_ack      in   1   mux grant; write done on clock where valid&&ack
//  riscv_reset_n    out  1   core reset, low while not DONE
//  load_done        out  1   high in DONE
//  words_written    out  16  count of words written this load
// BEHAVIOUR
//  Reset: state=IDLE. byte_ready=0, mem_req_valid=0, riscv_reset_n=0,
//   load_done=0, words_written=0, assembly reg=0, byte index=0.
//  States: IDLE, ADDR, COUNT, DATA, WRITE, DONE.
//  IDLE: wait for load_start -> ADDR. byte_ready=0.
//  DONE: load_done=1, riscv_reset_n=1. load_start -> ADDR (core back into
//   reset the next cycle, load_done clears, words_written clears).
//  load_start is ignored in ADDR/COUNT/DATA/WRITE.
//  ADDR/COUNT/DATA: byte_ready=1. Byte is accepted on an enabled edge with
//   byte_valid&&byte_ready. Byte k (0..3) goes to bits [8k+7:8k]. The 2-bit
//   index increments and wraps 3->0.
//  4th byte of ADDR: base = word & ADDR_MASK -> COUNT.
//  4th byte of COUNT: remaining = word. If 0 -> DONE, else -> DATA.
//   Counts above 2^16-1 are legal; words_written saturates at 16'hffff.
//  4th byte of DATA: latch word -> WRITE.
//  WRITE: byte_ready=0. mem_req_valid=1. Address, data and byte_en stay
//   stable until ack.
//   On valid&&ack: address=(address+4)&ADDR_MASK (wraps inside the SRAM),
//   remaining-=1, words_written+=1. If remaining becomes 0 -> DONE, else -> DATA.
//  Latency: minimum 5 cycles per word (4 bytes + 1 write when ack is already high).
//   riscv_reset_n rises on the edge after the last ack.
//  mem_req_valid never asserts outside WRITE. No byte is consumed in WRITE,
//   so there is no overrun.
//  clk__enable low: all registers hold, outputs stay stable.
//  reset mid-load: immediate return to IDLE. Partial word is discarded and
//   no further write issues. Writes already completed stay in SRAM.
// TESTING
//  1) Stream 00 01 00 00, 02 00 00 00, 13 00 00 00, 6f 00 00 00, ack=1 ->
//     writes 0x13 @0x100 then 0x6f @0x104; riscv_reset_n=1; words_written=2.
//  2) Count=0 (addr 0x40, count 00 00 00 00) -> DONE with no mem_req_valid;
//     load_done=1.
//  3) Addr 0x0000fffc, N=2 -> writes @0xfffc then @0x0000 (mask wrap).
//  4) ack held low 7 cycles in WRITE -> valid/address/data stable; byte_ready=0;
//     an offered byte is not consumed; write completes on the first ack.
//  5) byte_valid toggled randomly, clk__enable 50% -> same SRAM image as 1).
//  6) reset asserted after 2 data bytes, then new load_start + full load ->
//     only the new load's words are written; the old partial word never appears.

Source files
------------

// File: rtl/riscv_mem_loader.sv
// Byte-stream program loader: assembles little-endian words from a debug/UART
// stream, writes them to the shared SRAM and holds the core in reset until done.
module riscv_mem_loader #(
  parameter logic [31:0] ADDR_MASK = 32'h0000_fffc
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_address,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_byte_en,
  input  logic        mem_req_ack,
  output logic        riscv_reset_n,
  output logic        load_done,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  byte_idx_reg;
  logic [31:0] asm_word;
  logic [31:0] word_full;
  logic [31:0] address_reg;
  logic [31:0] remaining_reg;
  logic [31:0] data_reg;
  logic [15:0] words_written_reg;
  logic        byte_ready_reg;
  logic        mem_req_valid_reg;
  logic [3:0]  mem_req_byte_en_reg;
  logic        riscv_reset_n_reg;
  logic        load_done_reg;

  logic byte_fire;
  logic word_complete;
  logic write_fire;
  logic restart;

  assign byte_fire     = clk__enable && byte_valid && byte_ready_reg;
  assign word_complete = byte_fire && (byte_idx_reg == 2'd3);
  assign write_fire    = clk__enable && mem_req_valid_reg && mem_req_ack;
  assign restart       = clk__enable && load_start &&
                         ((state_reg == IDLE) || (state_reg == DONE));

  // One register per byte lane; lane k captures the k-th byte of each word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_reg <= 8'h00;
        end else if (byte_fire && (byte_idx_reg == 2'(gi))) begin
          lane_reg <= byte_data;
        end
      end
      assign asm_word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  // The 4th byte is used straight from the stream so the word is ready on its edge.
  assign word_full = {byte_data, asm_word[23:0]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (restart) state_next = ADDR;
      ADDR:  if (word_complete) state_next = COUNT;
      COUNT: if (word_complete) state_next = (word_full == 32'd0) ? DONE : DATA;
      DATA:  if (word_complete) state_next = WRITE;
      WRITE: if (write_fire) state_next = (remaining_reg == 32'd1) ? DONE : DATA;
      DONE:  if (restart) state_next = ADDR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg           <= IDLE;
      byte_idx_reg        <= 2'd0;
      address_reg         <= 32'd0;
      remaining_reg       <= 32'd0;
      data_reg            <= 32'd0;
      words_written_reg   <= 16'd0;
      byte_ready_reg      <= 1'b0;
      mem_req_valid_reg   <= 1'b0;
      mem_req_byte_en_reg <= 4'h0;
      riscv_reset_n_reg   <= 1'b0;
      load_done_reg       <= 1'b0;
    end else if (clk__enable) begin
      state_reg           <= state_next;
      // Outputs are decoded from the next state so they change with it.
      byte_ready_reg      <= (state_next == ADDR) || (state_next == COUNT) ||
                             (state_next == DATA);
      mem_req_valid_reg   <= (state_next == WRITE);
      mem_req_byte_en_reg <= (state_next == WRITE) ? 4'hf : 4'h0;
      riscv_reset_n_reg   <= (state_next == DONE);
      load_done_reg       <= (state_next == DONE);

      if (byte_fire) begin
        byte_idx_reg <= byte_idx_reg + 2'd1;
      end

      if (restart) begin
        byte_idx_reg      <= 2'd0;
        words_written_reg <= 16'd0;
      end

      if (word_complete) begin
        case (state_reg)
          ADDR:    address_reg   <= word_full & ADDR_MASK;
          COUNT:   remaining_reg <= word_full;
          DATA:    data_reg      <= word_full;
          default: ;
        endcase
      end

      if (write_fire) begin
        address_reg   <= (address_reg + 32'd4) & ADDR_MASK;
        remaining_reg <= remaining_reg - 32'd1;
        if (words_written_reg != 16'hffff) begin
          words_written_reg <= words_written_reg + 16'd1;
        end
      end
    end
  end

  assign byte_ready      = byte_ready_reg;
  assign mem_req_valid   = mem_req_valid_reg;
  assign mem_req_address = address_reg;
  assign mem_req_data    = data_reg;
  assign mem_req_byte_en = mem_req_byte_en_reg;
  assign riscv_reset_n   = riscv_reset_n_reg;
  assign load_done       = load_done_reg;
  assign words_written   = words_written_reg;

endmodule

// File: tb/tb_riscv_mem_loader.sv
// Directed bench for riscv_mem_loader: streams loads and checks the SRAM
// write log and the loader's status outputs against hand-computed values.
module tb_riscv_mem_loader;

  logic        clk = 1'b0;
  logic        clk__enable = 1'b1;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_address;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_byte_en;
  logic        mem_req_ack = 1'b1;
  logic        riscv_reset_n;
  logic        load_done;
  logic [15:0] words_written;

  int total = 0;
  int bad = 0;
  bit rnd = 1'b0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  riscv_mem_loader dut (
    .clk             (clk),
    .clk__enable     (clk__enable),
    .reset           (reset),
    .load_start      (load_start),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .mem_req_valid   (mem_req_valid),
    .mem_req_address (mem_req_address),
    .mem_req_data    (mem_req_data),
    .mem_req_byte_en (mem_req_byte_en),
    .mem_req_ack     (mem_req_ack),
    .riscv_reset_n   (riscv_reset_n),
    .load_done       (load_done),
    .words_written   (words_written)
  );

  always #5 clk = ~clk;

  // SRAM write log: one entry per completed write.
  always @(posedge clk) begin
    if (!reset && clk__enable && mem_req_valid && mem_req_ack) begin
      wa_q.push_back(mem_req_address);
      wd_q.push_back(mem_req_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s val=%h", tag, got);
    end
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    if (i < wa_q.size()) begin
      chk({tag, "_addr"}, wa_q[i], a);
      chk({tag, "_data"}, wd_q[i], d);
    end else begin
      chk({tag, "_missing"}, wa_q.size(), i + 1);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    clk__enable = 1'b1;
    byte_valid  = 1'b0;
    load_start  = 1'b1;
    @(negedge clk);
    load_start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      byte_data = b;
      if (rnd) begin
        byte_valid  = ($urandom_range(0, 1) == 1);
        clk__enable = ($urandom_range(0, 1) == 1);
      end else begin
        byte_valid  = 1'b1;
        clk__enable = 1'b1;
      end
      @(posedge clk);
      if (byte_valid && byte_ready && clk__enable) done = 1'b1;
    end
    if (!done) chk("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      if (load_done) ok = 1'b1;
      else if (rnd) clk__enable = ($urandom_range(0, 1) == 1);
      else clk__enable = 1'b1;
    end
    clk__enable = 1'b1;
    chk(tag, {31'd0, load_done}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_core_n", {31'd0, riscv_reset_n}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_ww", {16'd0, words_written}, 32'd0);
    chk("rst_be", {28'd0, mem_req_byte_en}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_byte_ready", {31'd0, byte_ready}, 32'd0);

    // 1) two-word load at 0x100, ack always high
    start_load();
    chk("t1_byte_ready", {31'd0, byte_ready}, 32'd1);
    chk("t1_core_n_low", {31'd0, riscv_reset_n}, 32'd0);
    send_word(32'h0000_0100);
    send_word(32'h0000_0002);
    send_word(32'h0000_0013);
    send_word(32'h0000_006f);
    @(negedge clk);
    chk("t1_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("t1_addr", mem_req_address, 32'h104);
    chk("t1_data", mem_req_data, 32'h6f);
    chk("t1_be", {28'd0, mem_req_byte_en}, 32'hf);
    chk("t1_write_byte_ready", {31'd0, byte_ready}, 32'd0);
    @(negedge clk);
    chk("t1_done", {31'd0, load_done}, 32'd1);
    chk("t1_core_n", {31'd0, riscv_reset_n}, 32'd1);
    chk("t1_ww", {16'd0, words_written}, 32'd2);
    chk("t1_nwr", wa_q.size(), 32'd2);
    chk_wr("t1_w0", 0, 32'h100, 32'h13);
    chk_wr("t1_w1", 1, 32'h104, 32'h6f);

    // 2) count of zero finishes without any write
    wa_q.delete(); wd_q.delete();
    start_load();
    chk("t2_done_clr", {31'd0, load_done}, 32'd0);
    chk("t2_core_n_clr", {31'd0, riscv_reset_n}, 32'd0);
    chk("t2_ww_clr", {16'd0, words_written}, 32'd0);
    send_word(32'h0000_0040);
    send_word(32'h0000_0000);
    @(negedge clk);
    chk("t2_done", {31'd0, load_done}, 32'd1);
    chk("t2_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("t2_nwr", wa_q.size(), 32'd0);

    // 3) address wraps inside the 64KB window
    wa_q.delete(); wd_q.delete();
    start_load();
    send_word(32'h0000_fffc);
    send_word(32'h0000_0002);
    send_word(32'haabb_ccdd);
    send_word(32'h1122_3344);
    wait_done("t3_done");
    chk("t3_nwr", wa_q.size(), 32'd2);
    chk_wr("t3_w0", 0, 32'h0000_fffc, 32'haabb_ccdd);
    chk_wr("t3_w1", 1, 32'h0000_0000, 32'h1122_3344);
    chk("t3_ww", {16'd0, words_written}, 32'd2);

    // 4) ack held low: request stays stable, offered byte not taken
    wa_q.delete(); wd_q.delete();
    mem_req_ack = 1'b0;
    start_load();
    send_word(32'h0000_0200);
    send_word(32'h0000_0001);
    send_word(32'hdead_beef);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      byte_data  = 8'h55;
      byte_valid = 1'b1;
      chk("t4_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("t4_addr", mem_req_address, 32'h200);
      chk("t4_data", mem_req_data, 32'hdead_beef);
      chk("t4_byte_ready", {31'd0, byte_ready}, 32'd0);
    end
    clk__enable = 1'b0;
    mem_req_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_hold_nwr", wa_q.size(), 32'd0);
    chk("t4_hold_valid", {31'd0, mem_req_valid}, 32'd1);
    clk__enable = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    chk("t4_done", {31'd0, load_done}, 32'd1);
    chk("t4_nwr", wa_q.size(), 32'd1);
    chk_wr("t4_w0", 0, 32'h200, 32'hdead_beef);
    chk("t4_ww", {16'd0, words_written}, 32'd1);

    // 5) random byte_valid and clock enable, same image as load 1
    wa_q.delete(); wd_q.delete();
    rnd = 1'b1;
    start_load();
    send_word(32'h0000_0100);
    send_word(32'h0000_0002);
    send_word(32'h0000_0013);
    send_word(32'h0000_006f);
    wait_done("t5_done");
    rnd = 1'b0;
    chk("t5_nwr", wa_q.size(), 32'd2);
    chk_wr("t5_w0", 0, 32'h100, 32'h13);
    chk_wr("t5_w1", 1, 32'h104, 32'h6f);
    chk("t5_ww", {16'd0, words_written}, 32'd2);

    // 6) reset after two data bytes, then a fresh load
    wa_q.delete(); wd_q.delete();
    start_load();
    send_word(32'h0000_0300);
    send_word(32'h0000_0001);
    send_byte(8'h99);
    send_byte(8'h88);
    @(negedge clk);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("t6_rst_core_n", {31'd0, riscv_reset_n}, 32'd0);
    chk("t6_rst_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("t6_rst_ww", {16'd0, words_written}, 32'd0);
    reset = 1'b0;
    start_load();
    send_word(32'h0000_0400);
    send_word(32'h0000_0001);
    send_word(32'h1234_5678);
    wait_done("t6_done");
    chk("t6_nwr", wa_q.size(), 32'd1);
    chk_wr("t6_w0", 0, 32'h400, 32'h1234_5678);
    chk("t6_ww", {16'd0, words_written}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
